// File: rtl/dffre_bank_pkg.sv
// Shared definitions for the dffre bank write arbiter.
//   state_t    : controller state (IDLE / CLEAR)
//   ceil_log2  : ceiling log2, used for the grant index width
//   onehot     : word index -> one-hot word enable, zero when out of range
package dffre_bank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Widest bank the controller supports; onehot() works at this width and
  // callers size-cast the result down to their own DEPTH.
  localparam int MAX_DEPTH = 16;
  localparam int MAX_AW    = 4;

  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Indices at or beyond depth yield all-zero so nothing gets written.
  function automatic logic [MAX_DEPTH-1:0] onehot(input logic [MAX_AW-1:0] idx,
                                                  input int depth);
    logic [MAX_DEPTH-1:0] v;
    v = '0;
    if (int'(idx) < depth) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dffre_bank_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req       : request vector
//   ptr       : index with highest priority this cycle
//   grant     : one-hot grant (zero when no request)
//   grant_idx : binary index of the granted requester
//   grant_vld : some requester was granted
module rr_arbiter
  import dffre_bank_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int IW   = (ceil_log2(N_REQ) < 1) ? 1 : ceil_log2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             grant_vld
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate back towards ptr so the closest
  // requesting index (in wrap-around order) is the last one written.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr) + i) % N_REQ);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_vld   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dffre_bank_write_arbiter.sv
// Write controller for a bank of DEPTH enable-gated reset flops.
// Round-robin shares the bank write path among N_REQ requesters and runs a
// clear sweep that zeroes one word per cycle. All outputs are registered.
//   clk      : clock
//   i_Reset  : asynchronous active-high reset
//   i_Req    : per-requester write request, held until its ack
//   i_Addr   : per-requester word address, slice k = requester k
//   i_Data   : per-requester write data, slice k = requester k
//   i_Clear  : pulse that starts a clear sweep
//   o_Ack    : one-hot commit pulse to the granted requester
//   o_Enable : one-hot (or zero) word enable into the bank
//   o_D      : data into the bank
//   o_Busy   : clear sweep in progress
module dffre_bank_write_arbiter
  import dffre_bank_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int IW   = (ceil_log2(N_REQ) < 1) ? 1 : ceil_log2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   i_Reset,
  input  logic [N_REQ-1:0]       i_Req,
  input  logic [N_REQ*AW-1:0]    i_Addr,
  input  logic [N_REQ*WIDTH-1:0] i_Data,
  input  logic                   i_Clear,
  output logic [N_REQ-1:0]       o_Ack,
  output logic [DEPTH-1:0]       o_Enable,
  output logic [WIDTH-1:0]       o_D,
  output logic                   o_Busy
);

  state_t            state;
  logic [AW-1:0]     cnt;
  logic [IW-1:0]     ptr;

  logic [AW-1:0]     addr_arr [N_REQ];
  logic [WIDTH-1:0]  data_arr [N_REQ];

  logic [N_REQ-1:0]  grant;
  logic [IW-1:0]     grant_idx;
  logic              grant_vld;
  logic [DEPTH-1:0]  addr_oh;
  logic [DEPTH-1:0]  cnt_oh;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      addr_arr[k] = i_Addr[k*AW +: AW];
      data_arr[k] = i_Data[k*WIDTH +: WIDTH];
    end
  end

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr (
    .req      (i_Req),
    .ptr      (ptr),
    .grant    (grant),
    .grant_idx(grant_idx),
    .grant_vld(grant_vld)
  );

  always_comb begin
    addr_oh = DEPTH'(onehot(MAX_AW'(addr_arr[grant_idx]), DEPTH));
    cnt_oh  = DEPTH'(onehot(MAX_AW'(cnt), DEPTH));
  end

  // ---- decision -> registered outputs (one cycle latency) ----
  always_ff @(posedge clk or posedge i_Reset) begin
    if (i_Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      o_Ack    <= '0;
      o_Enable <= '0;
      o_D      <= '0;
      o_Busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_Busy <= 1'b0;
          if (i_Clear) begin
            // Clear wins over any pending request this cycle.
            state    <= CLEAR;
            cnt      <= '0;
            o_Ack    <= '0;
            o_Enable <= '0;
          end else if (grant_vld) begin
            o_Ack    <= grant;
            o_Enable <= addr_oh;
            o_D      <= data_arr[grant_idx];
            if (int'(grant_idx) == N_REQ - 1) ptr <= '0;
            else                              ptr <= grant_idx + 1'b1;
          end else begin
            o_Ack    <= '0;
            o_Enable <= '0;
          end
        end
        CLEAR: begin
          // Requests and further clears are left waiting; ptr is untouched.
          o_Ack    <= '0;
          o_Enable <= cnt_oh;
          o_D      <= '0;
          o_Busy   <= 1'b1;
          if (cnt == AW'(DEPTH - 1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dffre_bank_write_arbiter.sv
module tb_dffre_bank_write_arbiter;

  localparam int N_REQ = 2;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [AW-1:0]          a0, a1;
  logic [WIDTH-1:0]       d0, d1;
  logic                   clear;
  logic [N_REQ-1:0]       o_Ack;
  logic [DEPTH-1:0]       o_Enable;
  logic [WIDTH-1:0]       o_D;
  logic                   o_Busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dffre_bank_write_arbiter #(
    .N_REQ(N_REQ),
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .i_Reset (rst),
    .i_Req   (req),
    .i_Addr  ({a1, a0}),
    .i_Data  ({d1, d0}),
    .i_Clear (clear),
    .o_Ack   (o_Ack),
    .o_Enable(o_Enable),
    .o_D     (o_D),
    .o_Busy  (o_Busy)
  );

  // Bank of dffre words driven by the DUT.
  logic [WIDTH-1:0] bank [DEPTH];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) if (o_Enable[i]) bank[i] <= o_D;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] ack, input logic [3:0] en,
                         input logic [7:0] d, input logic busy);
    chk({tag, "_ack"}, 32'(o_Ack), 32'(ack));
    chk({tag, "_en"}, 32'(o_Enable), 32'(en));
    chk({tag, "_d"}, 32'(o_D), 32'(d));
    chk({tag, "_busy"}, 32'(o_Busy), 32'(busy));
  endtask

  // Reference model state for the random phase.
  int               m_ptr, m_cnt;
  bit               m_clear;
  logic [1:0]       exp_ack;
  logic [3:0]       exp_en;
  logic [7:0]       exp_d;
  logic             exp_busy;
  logic [7:0]       bank_m [DEPTH];
  logic [AW-1:0]    ma [N_REQ];
  logic [WIDTH-1:0] md [N_REQ];

  initial begin
    // Reset with requests pending.
    rst = 1'b1; clear = 1'b0; req = 2'b11;
    a0 = 2'd0; d0 = 8'hA5; a1 = 2'd2; d1 = 8'h3C;
    repeat (2) step();
    chk_out("reset", 2'b00, 4'b0000, 8'h00, 1'b0);
    rst = 1'b0;
    step();
    chk_out("first_grant", 2'b01, 4'b0001, 8'hA5, 1'b0);

    // Contention: pointer now favours requester 1.
    a0 = 2'd1; d0 = 8'h11; a1 = 2'd3; d1 = 8'h22;
    step(); chk_out("cont1", 2'b10, 4'b1000, 8'h22, 1'b0);
    step(); chk_out("cont2", 2'b01, 4'b0010, 8'h11, 1'b0);
    step(); chk_out("cont3", 2'b10, 4'b1000, 8'h22, 1'b0);
    step(); chk_out("cont4", 2'b01, 4'b0010, 8'h11, 1'b0);
    req = 2'b00;
    step(); chk_out("idle_hold", 2'b00, 4'b0000, 8'h11, 1'b0);

    // Single requester streaming.
    req = 2'b10; a1 = 2'd2; d1 = 8'h5A;
    step(); chk_out("stream1", 2'b10, 4'b0100, 8'h5A, 1'b0);
    step(); chk_out("stream2", 2'b10, 4'b0100, 8'h5A, 1'b0);
    step(); chk_out("stream3", 2'b10, 4'b0100, 8'h5A, 1'b0);

    // Clear beats a same-cycle request; request waits for the sweep.
    clear = 1'b1; req = 2'b01; a0 = 2'd3; d0 = 8'h77;
    step(); chk_out("clr_start", 2'b00, 4'b0000, 8'h5A, 1'b0);
    clear = 1'b0;
    step(); chk_out("sweep0", 2'b00, 4'b0001, 8'h00, 1'b1);
    clear = 1'b1;
    step(); chk_out("sweep1", 2'b00, 4'b0010, 8'h00, 1'b1);
    clear = 1'b0;
    step(); chk_out("sweep2", 2'b00, 4'b0100, 8'h00, 1'b1);
    step(); chk_out("sweep3", 2'b00, 4'b1000, 8'h00, 1'b1);
    step(); chk_out("after_sweep", 2'b01, 4'b1000, 8'h77, 1'b0);
    req = 2'b00;
    step(); chk_out("no_restart", 2'b00, 4'b0000, 8'h77, 1'b0);

    // Asynchronous reset in the middle of a sweep.
    clear = 1'b1; req = 2'b10; a1 = 2'd1; d1 = 8'h99;
    step();
    clear = 1'b0;
    step(); chk_out("rs_sweep0", 2'b00, 4'b0001, 8'h00, 1'b1);
    step(); chk_out("rs_sweep1", 2'b00, 4'b0010, 8'h00, 1'b1);
    #2 rst = 1'b1;
    #1 chk_out("async_rst", 2'b00, 4'b0000, 8'h00, 1'b0);
    step();
    rst = 1'b0; req = 2'b11; a0 = 2'd2; d0 = 8'hC3;
    step(); chk_out("post_rst", 2'b01, 4'b0100, 8'hC3, 1'b0);
    req = 2'b00;

    // Random phase against a behavioural model, starting from reset.
    rst = 1'b1; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    step();
    rst = 1'b0;
    m_ptr = 0; m_cnt = 0; m_clear = 1'b0;
    exp_ack = '0; exp_en = '0; exp_d = '0; exp_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) bank_m[i] = '0;
    @(negedge clk);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk);
      for (int i = 0; i < DEPTH; i++) if (exp_en[i]) bank_m[i] = exp_d;
      ma[0] = a0; ma[1] = a1; md[0] = d0; md[1] = d1;
      if (!m_clear) begin
        exp_busy = 1'b0;
        if (clear) begin
          m_clear = 1'b1; m_cnt = 0; exp_ack = '0; exp_en = '0;
        end else if (req != 2'b00) begin
          int k;
          k = req[m_ptr] ? m_ptr : (m_ptr + 1) % N_REQ;
          exp_ack = '0; exp_ack[k] = 1'b1;
          exp_en = '0; exp_en[ma[k]] = 1'b1;
          exp_d = md[k];
          m_ptr = (k + 1) % N_REQ;
        end else begin
          exp_ack = '0; exp_en = '0;
        end
      end else begin
        exp_ack = '0; exp_en = '0; exp_en[m_cnt] = 1'b1; exp_d = '0; exp_busy = 1'b1;
        if (m_cnt == DEPTH - 1) m_clear = 1'b0;
        m_cnt = (m_cnt + 1) % DEPTH;
      end
      @(negedge clk);
      chk("gold_bank", {bank[3], bank[2], bank[1], bank[0]},
          {bank_m[3], bank_m[2], bank_m[1], bank_m[0]});
      chk("gold_ack", 32'(o_Ack), 32'(exp_ack));
      chk("gold_busy", 32'(o_Busy), 32'(exp_busy));
      chk("gold_onehot_en", 32'($onehot0(o_Enable)), 32'd1);
      chk("gold_onehot_ack", 32'($onehot0(o_Ack)), 32'd1);
      if (!req[0] || exp_ack[0]) begin
        req[0] = ($urandom_range(0, 9) < 6);
        a0 = AW'($urandom_range(0, DEPTH - 1));
        d0 = WIDTH'($urandom);
      end
      if (!req[1] || exp_ack[1]) begin
        req[1] = ($urandom_range(0, 9) < 6);
        a1 = AW'($urandom_range(0, DEPTH - 1));
        d1 = WIDTH'($urandom);
      end
      clear = ($urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dffre_bank_write_arbiter.md
Name: dffre_bank_write_arbiter

Overview:
- Write controller and arbiter for a bank of DEPTH enable-gated reset flops (dffre words, WIDTH bits each).
- Shares the bank's write path between N_REQ requesters using round-robin arbitration.
- Drives a one-hot per-word enable and a shared data bus into the bank.
- Also runs a bank-clear sweep that writes zero to every word, one word per cycle.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- WIDTH, 8, bits per bank word.
- DEPTH, 4, number of bank words (2..16).
- AW, $clog2(DEPTH), address width (derived, not overridden).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Req  in  N_REQ  per-requester write request; held until the matching o_Ack.
- i_Addr  in  N_REQ*AW  per-requester word address; slice k belongs to requester k; stable while i_Req[k] is high.
- i_Data  in  N_REQ*WIDTH  per-requester write data; slice k belongs to requester k; stable while i_Req[k] is high.
- i_Clear  in  1  single-cycle pulse that starts a clear sweep.
- o_Ack  out  N_REQ  one-hot, one-cycle pulse: requester's write is committed this cycle.
- o_Enable  out  DEPTH  one-hot (or zero) per-word enable to the bank.
- o_D  out  WIDTH  data to the bank, valid when o_Enable is non-zero.
- o_Busy  out  1  high while a clear sweep is in progress.

Behaviour:
- Reset (asynchronous, i_Reset=1):
  - o_Ack=0, o_Enable=0, o_D=0, o_Busy=0.
  - State=IDLE, sweep counter=0.
  - Round-robin pointer=0, so requester 0 has highest priority first.
- Outputs are registered. A decision made in cycle t appears on o_Ack/o_Enable/o_D in cycle t+1, a fixed latency of 1.
- FSM has two states, IDLE and CLEAR.
- IDLE:
  - If i_Clear=1: go to CLEAR, counter=0. Clear beats requests in the same cycle; no grant, no ack.
  - Else if any i_Req bit is set: grant one requester by round robin, searching from (last_grant+1) mod N_REQ upward.
  - Next cycle for the granted requester k: o_Ack[k]=1, o_Enable=onehot(i_Addr[k]), o_D=i_Data[k].
  - The pointer then moves past k.
  - Else: o_Ack=0, o_Enable=0; o_D holds its last value.
- At most one grant per cycle. With requests pending and no clear, grants are back to back with no idle cycle.
- A requester that keeps i_Req high after its ack is a new request. It is re-granted immediately only if no other requester is pending.
- Out-of-range address (i_Addr[k] >= DEPTH, possible only when DEPTH is not a power of 2): the requester is acked, o_Enable=0, nothing is written.
- CLEAR:
  - Each cycle: o_Enable=onehot(counter), o_D=0, o_Busy=1, counter+1.
  - After word DEPTH-1 is emitted, return to IDLE. o_Busy falls in the cycle after the last word's enable.
  - The sweep occupies exactly DEPTH enable cycles.
  - i_Req is not granted during CLEAR; pending requests wait and are not dropped.
  - i_Clear during CLEAR is ignored; no restart, no extension.
- Reset mid-sweep or mid-grant: outputs drop to 0 immediately (asynchronously). No ack is issued for the in-flight grant; the requester keeps requesting after reset.
- The round-robin pointer is preserved across a clear sweep.
- Invariant: o_Enable is never multi-hot, and o_Ack is never multi-hot.

Decomposition:
- Package dffre_bank_pkg holds:
  - typedef enum state_t {IDLE, CLEAR};
  - a onehot function: AW-bit index -> DEPTH-bit vector, returning zero when out of range.
  - a ceil-log2 helper used for the grant index width.
- One sub-module, rr_arbiter (N_REQ parameter):
  - combinational round-robin pick from the request vector and pointer;
  - outputs a one-hot grant and a grant index.
- The FSM, sweep counter and output registers live in dffre_bank_write_arbiter.

Test Plan:
- Reset: hold i_Reset=1 while i_Req=2'b11 -> all outputs 0. Release, then the first grant goes to requester 0: o_Ack=2'b01, o_Enable=4'b0001 for i_Addr[0]=0, o_D=i_Data[0]=8'hA5.
- Contention: i_Req=2'b11 held for 4 cycles -> o_Ack sequence 01,10,01,10 with no idle cycle. o_Enable/o_D track each winner's addr/data (addr0=1, addr1=3 -> 0010, 1000 alternating).
- Single requester streaming: i_Req=2'b10 held for 3 cycles -> o_Ack=10 on 3 consecutive cycles, starting 1 cycle after first req.
- Clear: i_Clear pulse with i_Req=2'b01 in the same cycle -> o_Busy=1 for 4 cycles, o_Enable=0001,0010,0100,1000, o_D=0. Requester 0 is acked in the cycle after the sweep; a second i_Clear mid-sweep has no effect.
- Async reset mid-sweep: assert i_Reset between clock edges on sweep cycle 2 -> o_Enable, o_Busy and o_Ack drop to 0 before the next edge. After release, state=IDLE and the next grant goes to requester 0.
- Golden compare: drive the bank (4 dffre words) from the DUT with random req/addr/data/clear for 200 cycles. Check bank contents against a behavioural model at each negedge: zero mismatches, and no multi-hot o_Enable ever.
